// File: rtl/ysyx_22040632_axi_pkg.sv
// Shared definitions for the single-outstanding AXI4 master: FSM states,
// AXI burst/response codes and default bus widths.
package ysyx_22040632_axi_pkg;

    localparam int AXI_AW  = 32;
    localparam int AXI_DW  = 64;
    localparam int AXI_IDW = 4;
    localparam int CNT_W   = 8;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5,
        ST_DONE = 3'd6
    } axi_state_e;

endpackage

// File: rtl/ysyx_22040632_axi_master.sv
// AXI4 master bridging a simple arbiter request port to one AXI burst at a
// time. The request is latched on acceptance and owns the bus until DONE;
// protocol anomalies (bad resp, wrong id, rlast/wlast disagreement) are
// collected into a per-transaction error flag reported alongside rw_ready.
module ysyx_22040632_axi_master
    import ysyx_22040632_axi_pkg::*;
#(
    parameter int AW    = AXI_AW,
    parameter int DW    = AXI_DW,
    parameter int IDW   = AXI_IDW,
    parameter int TX_ID = 0
) (
    input  logic              clk,
    input  logic              rrst,
    // arbiter side
    input  logic              rw_valid,
    input  logic              rw_req,
    input  logic [AW-1:0]     rw_addr,
    input  logic [2:0]        rw_size,
    input  logic [7:0]        rw_len,
    input  logic [DW/8-1:0]   w_strb,
    input  logic [DW-1:0]     rw_w_data,
    input  logic              w_last,
    output logic              rw_ready,
    output logic [DW-1:0]     data_read,
    output logic              r_hs,
    output logic              r_last,
    output logic              w_hs,
    output logic              axi_write_ahead,
    output logic              resp_err,
    // AW channel
    output logic              awvalid,
    input  logic              awready,
    output logic [AW-1:0]     awaddr,
    output logic [IDW-1:0]    awid,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    // W channel
    output logic              wvalid,
    input  logic              wready,
    output logic [DW-1:0]     wdata,
    output logic [DW/8-1:0]   wstrb,
    output logic              wlast,
    // B channel
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    input  logic [IDW-1:0]    bid,
    // AR channel
    output logic              arvalid,
    input  logic              arready,
    output logic [AW-1:0]     araddr,
    output logic [IDW-1:0]    arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    // R channel
    input  logic              rvalid,
    output logic              rready,
    input  logic [DW-1:0]     rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic [IDW-1:0]    rid
);

    localparam logic [IDW-1:0] MY_ID = IDW'(TX_ID);

    axi_state_e          state_reg;
    logic [AW-1:0]       addr_reg;
    logic [2:0]          size_reg;
    logic [CNT_W-1:0]    len_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                err_reg;
    logic [DW-1:0]       data_read_reg;
    logic                r_hs_reg;
    logic                r_last_reg;
    logic                rw_ready_reg;
    logic                resp_err_reg;
    logic                ahead_reg;
    logic                arvalid_reg;
    logic                awvalid_reg;
    logic                wvalid_reg;
    logic                rready_reg;
    logic                bready_reg;

    // Current beat is the final one of the burst (counter reached latched len).
    logic beat_last;
    logic r_beat_err;
    logic w_beat_err;
    logic b_err;

    // Per-beat/per-response anomaly detection feeding the sticky error flag.
    always_comb begin
        beat_last  = (cnt_reg == len_reg);
        r_beat_err = (rresp != AXI_RESP_OKAY) || (rid != MY_ID) || (rlast != beat_last);
        w_beat_err = (w_last != beat_last);
        b_err      = (bresp != AXI_RESP_OKAY) || (bid != MY_ID);
    end

    // Transaction FSM: latches the request, walks the AXI channels, one pulse per event.
    always_ff @(posedge clk or posedge rrst) begin
        if (rrst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            size_reg      <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
            data_read_reg <= '0;
            r_hs_reg      <= 1'b0;
            r_last_reg    <= 1'b0;
            rw_ready_reg  <= 1'b0;
            resp_err_reg  <= 1'b0;
            ahead_reg     <= 1'b0;
            arvalid_reg   <= 1'b0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            rready_reg    <= 1'b0;
            bready_reg    <= 1'b0;
        end else begin
            r_hs_reg     <= 1'b0;
            r_last_reg   <= 1'b0;
            rw_ready_reg <= 1'b0;
            resp_err_reg <= 1'b0;
            ahead_reg    <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (rw_valid) begin
                        addr_reg <= rw_addr;
                        size_reg <= rw_size;
                        len_reg  <= rw_len;
                        cnt_reg  <= '0;
                        err_reg  <= 1'b0;
                        if (rw_req) begin
                            awvalid_reg <= 1'b1;
                            state_reg   <= ST_AW;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        data_read_reg <= rdata;
                        r_hs_reg      <= 1'b1;
                        r_last_reg    <= beat_last;
                        if (beat_last) begin
                            // Completion is decided by our own count, never by rlast.
                            rready_reg   <= 1'b0;
                            rw_ready_reg <= 1'b1;
                            resp_err_reg <= err_reg | r_beat_err;
                            state_reg    <= ST_DONE;
                        end else begin
                            err_reg <= err_reg | r_beat_err;
                            if (cnt_reg != {CNT_W{1'b1}}) begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                ST_AW: begin
                    if (awready) begin
                        awvalid_reg <= 1'b0;
                        ahead_reg   <= 1'b1;
                        wvalid_reg  <= 1'b1;
                        state_reg   <= ST_W;
                    end
                end
                ST_W: begin
                    if (wready) begin
                        err_reg <= err_reg | w_beat_err;
                        if (beat_last) begin
                            wvalid_reg <= 1'b0;
                            bready_reg <= 1'b1;
                            state_reg  <= ST_B;
                        end else if (cnt_reg != {CNT_W{1'b1}}) begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        bready_reg   <= 1'b0;
                        rw_ready_reg <= 1'b1;
                        resp_err_reg <= err_reg | b_err;
                        state_reg    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Forced idle cycle: a request is never accepted here.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Output mapping: registered controls, constant burst/id, W data pass-through.
    always_comb begin
        rw_ready        = rw_ready_reg;
        data_read       = data_read_reg;
        r_hs            = r_hs_reg;
        r_last          = r_last_reg;
        axi_write_ahead = ahead_reg;
        resp_err        = resp_err_reg;

        awvalid = awvalid_reg;
        awaddr  = addr_reg;
        awid    = MY_ID;
        awlen   = len_reg;
        awsize  = size_reg;
        awburst = AXI_BURST_INCR;

        wvalid  = wvalid_reg;
        wdata   = rw_w_data;
        wstrb   = w_strb;
        wlast   = wvalid_reg & beat_last;
        w_hs    = wvalid_reg & wready;

        bready  = bready_reg;

        arvalid = arvalid_reg;
        araddr  = addr_reg;
        arid    = MY_ID;
        arlen   = len_reg;
        arsize  = size_reg;
        arburst = AXI_BURST_INCR;

        rready  = rready_reg;
    end

endmodule

// File: tb/tb_ysyx_22040632_axi_master.sv
// Directed bench for the AXI master: a transaction-level model predicts the
// arbiter-side pulses and AXI address/data fields every cycle, and each
// directed scenario is also pinned with hand-computed literal expectations.
module tb_ysyx_22040632_axi_master;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IDW = 4;

    logic clk = 1'b0;
    logic rrst = 1'b1;

    logic            rw_valid = 0, rw_req = 0, w_last = 0;
    logic [AW-1:0]   rw_addr = '0;
    logic [2:0]      rw_size = '0;
    logic [7:0]      rw_len = '0;
    logic [DW/8-1:0] w_strb = '0;
    logic [DW-1:0]   rw_w_data = '0;
    logic            rw_ready, r_hs, r_last, w_hs, axi_write_ahead, resp_err;
    logic [DW-1:0]   data_read;
    logic            awvalid, awready = 0;
    logic [AW-1:0]   awaddr;
    logic [IDW-1:0]  awid;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            wvalid, wready = 0, wlast;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid = 0, bready;
    logic [1:0]      bresp = 0;
    logic [IDW-1:0]  bid = 0;
    logic            arvalid, arready = 0;
    logic [AW-1:0]   araddr;
    logic [IDW-1:0]  arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            rvalid = 0, rready, rlast = 0;
    logic [DW-1:0]   rdata = '0;
    logic [1:0]      rresp = 0;
    logic [IDW-1:0]  rid = 0;

    ysyx_22040632_axi_master #(.AW(AW), .DW(DW), .IDW(IDW), .TX_ID(0)) dut (
        .clk(clk), .rrst(rrst),
        .rw_valid(rw_valid), .rw_req(rw_req), .rw_addr(rw_addr), .rw_size(rw_size),
        .rw_len(rw_len), .w_strb(w_strb), .rw_w_data(rw_w_data), .w_last(w_last),
        .rw_ready(rw_ready), .data_read(data_read), .r_hs(r_hs), .r_last(r_last),
        .w_hs(w_hs), .axi_write_ahead(axi_write_ahead), .resp_err(resp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model + observation counters ----------------
    int          cyc = 0;
    bit          busy = 0, m_req = 0, m_err = 0;
    logic [31:0] m_addr = 0;
    logic [7:0]  m_len = 0;
    logic [2:0]  m_size = 0;
    int          m_beats = 0;
    bit          exp_rhs = 0, exp_rlast = 0, exp_ahead = 0, exp_ready = 0, exp_err = 0, exp_addr = 0;
    logic [63:0] exp_rdata = 0;
    bit          prev_arwait = 0, prev_awwait = 0, prev_arv = 0, prev_awv = 0;

    int          obs_rhs = 0, obs_rlast_cnt = 0, obs_rlast_at = 0;
    int          obs_ready = 0, obs_aw = 0, obs_ar = 0, obs_ahead = 0;
    int          obs_whs = 0, obs_wlast_cnt = 0, obs_wlast_at = 0;
    bit          obs_err = 0;
    logic [63:0] obs_data [16];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rrst) begin
                check("rst_rw_ready", rw_ready, 0);
                check("rst_r_hs", r_hs, 0);
                check("rst_r_last", r_last, 0);
                check("rst_w_hs", w_hs, 0);
                check("rst_ahead", axi_write_ahead, 0);
                check("rst_resp_err", resp_err, 0);
                check("rst_data_read", data_read, 0);
                check("rst_valids", {arvalid, awvalid, wvalid, rready, bready, wlast}, 0);
                busy = 0; exp_rhs = 0; exp_ahead = 0; exp_ready = 0; exp_addr = 0;
                prev_arwait = 0; prev_awwait = 0; prev_arv = 0; prev_awv = 0;
            end else begin
                bit cur_ready;
                bit last;
                // compare against what the model predicted last cycle
                check("r_hs", r_hs, exp_rhs);
                if (exp_rhs) begin
                    check("data_read", data_read, exp_rdata);
                    check("r_last", r_last, exp_rlast);
                end
                check("write_ahead", axi_write_ahead, exp_ahead);
                check("rw_ready", rw_ready, exp_ready);
                if (exp_ready) check("resp_err", resp_err, exp_err);
                check("w_hs", w_hs, wvalid & wready);
                check("one_direction", (arvalid | rready) & (awvalid | wvalid | bready), 0);
                if (!busy) check("idle_quiet", {arvalid, awvalid, wvalid, rready, bready}, 0);
                if (exp_addr) check("addr_phase_start", {arvalid, awvalid}, m_req ? 2'b01 : 2'b10);
                if (prev_arwait) check("ar_hold", arvalid, 1);
                if (prev_awwait) check("aw_hold", awvalid, 1);
                if (arvalid) begin
                    check("araddr", araddr, m_addr);
                    check("arlen", arlen, m_len);
                    check("arsize", arsize, m_size);
                    check("arburst", arburst, 2'b01);
                    check("arid", arid, 0);
                end
                if (awvalid) begin
                    check("awaddr", awaddr, m_addr);
                    check("awlen", awlen, m_len);
                    check("awsize", awsize, m_size);
                    check("awburst", awburst, 2'b01);
                    check("awid", awid, 0);
                end
                if (wvalid) begin
                    check("wlast", wlast, m_beats == int'(m_len));
                    check("wdata", wdata, rw_w_data);
                    check("wstrb", wstrb, w_strb);
                end

                // observations for the directed literal checks
                if (r_hs) begin
                    obs_data[obs_rhs % 16] = data_read;
                    obs_rhs++;
                    if (r_last) begin obs_rlast_cnt++; obs_rlast_at = obs_rhs; end
                end
                if (axi_write_ahead) obs_ahead++;
                if (awvalid && !prev_awv) obs_aw++;
                if (arvalid && !prev_arv) obs_ar++;
                if (w_hs) begin
                    obs_whs++;
                    if (wlast) begin obs_wlast_cnt++; obs_wlast_at = obs_whs; end
                end
                if (rw_ready) begin
                    obs_ready++;
                    obs_err = resp_err;
                    $display("txn %0d complete at cycle %0d: %s addr=%08h len=%0d resp_err=%0b",
                             obs_ready, cyc, m_req ? "write" : "read", m_addr, m_len, resp_err);
                end

                // predict next cycle from the handshakes that occur at the coming edge
                cur_ready = exp_ready;
                exp_rhs = 0; exp_ahead = 0; exp_ready = 0; exp_addr = 0;
                if (busy) begin
                    if (rvalid && rready) begin
                        last = (m_beats == int'(m_len));
                        exp_rhs = 1; exp_rdata = rdata; exp_rlast = last;
                        if (rresp != 2'b00 || rid != 0 || rlast != last) m_err = 1;
                        if (last) begin exp_ready = 1; exp_err = m_err; busy = 0; end
                        else m_beats++;
                    end
                    if (wvalid && wready) begin
                        last = (m_beats == int'(m_len));
                        if (w_last != last) m_err = 1;
                        if (!last) m_beats++;
                    end
                    if (bvalid && bready) begin
                        exp_ready = 1;
                        exp_err = m_err | (bresp != 2'b00) | (bid != 0);
                        busy = 0;
                    end
                    if (awvalid && awready) exp_ahead = 1;
                end else if (!cur_ready && rw_valid) begin
                    busy = 1; m_req = rw_req; m_addr = rw_addr; m_len = rw_len; m_size = rw_size;
                    m_beats = 0; m_err = 0; exp_addr = 1;
                end
                prev_arwait = arvalid && !arready;
                prev_awwait = awvalid && !awready;
                prev_arv = arvalid;
                prev_awv = awvalid;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0: return arvalid;
            1: return awvalid;
            2: return wvalid;
            3: return bready;
            4: return rready;
            5: return rw_ready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string what, input int which);
        for (int i = 0; i < 40; i++) begin
            if (sig_of(which)) return;
            tick();
        end
        n_checks++;
        n_errors++;
        $display("FAIL timeout_%s: got 0, expected 1 within 40 cycles", what);
    endtask

    int b_rhs, b_rlast, b_ready, b_aw, b_ahead, b_whs, b_wlast;
    task automatic snap();
        b_rhs = obs_rhs; b_rlast = obs_rlast_cnt; b_ready = obs_ready; b_aw = obs_aw;
        b_ahead = obs_ahead; b_whs = obs_whs; b_wlast = obs_wlast_cnt;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int ar_delay,
                           input int gap, input int rlast_beat, input int bad_beat,
                           input logic [3:0] rid_v, input logic [63:0] base, input bit scramble);
        rw_valid = 1; rw_req = 0; rw_addr = addr; rw_len = len; rw_size = 3'd3;
        tick();
        rw_valid = 0;
        if (scramble) begin rw_addr = 32'hDEAD_BEEF; rw_len = 8'd9; rw_req = 1; rw_size = 3'd1; end
        wait_for("arvalid", 0);
        repeat (ar_delay) tick();
        arready = 1; tick(); arready = 0;
        wait_for("rready", 4);
        for (int b = 0; b <= int'(len); b++) begin
            repeat (gap) tick();
            rvalid = 1; rdata = base + 64'(b); rlast = (b == rlast_beat);
            rresp = (b == bad_beat) ? 2'b10 : 2'b00; rid = rid_v;
            tick();
            rvalid = 0; rlast = 0; rresp = 0; rid = 0;
        end
        wait_for("rw_ready", 5);
        tick();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int wr_low,
                            input logic [1:0] bresp_v, input int bad_beat, input logic [63:0] base);
        rw_valid = 1; rw_req = 1; rw_addr = addr; rw_len = len; rw_size = 3'd3;
        w_strb = 8'hF0; rw_w_data = base; w_last = (len == 0) ^ (bad_beat == 0);
        tick();
        rw_valid = 0;
        wait_for("awvalid", 1);
        awready = 1; tick(); awready = 0;
        wait_for("wvalid", 2);
        repeat (wr_low) tick();
        for (int b = 0; b <= int'(len); b++) begin
            rw_w_data = base + 64'(b); w_strb = 8'hF0 ^ 8'(b);
            w_last = (b == int'(len)) ^ (b == bad_beat);
            wready = 1;
            tick();
        end
        wready = 0; w_last = 0;
        wait_for("bready", 3);
        bvalid = 1; bresp = bresp_v; tick(); bvalid = 0; bresp = 0;
        wait_for("rw_ready", 5);
        tick();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rrst = 0;
        check("reset_data_read", data_read, 0);
        check("reset_rw_ready", rw_ready, 0);
        tick();

        // single read, arready after 2 cycles
        snap();
        do_read(32'h8000_0000, 8'd0, 2, 0, 0, -1, 4'd0, 64'h1122334455667788, 0);
        check("single_rd_rhs_count", obs_rhs - b_rhs, 1);
        check("single_rd_data", obs_data[b_rhs % 16], 64'h1122334455667788);
        check("single_rd_rlast_count", obs_rlast_cnt - b_rlast, 1);
        check("single_rd_ready_count", obs_ready - b_ready, 1);
        check("single_rd_resp_err", obs_err, 0);

        // burst read len 3 with gaps, rlast early on 3rd beat
        snap();
        do_read(32'h8000_1000, 8'd3, 0, 2, 2, -1, 4'd0, 64'hA0A0_0000_0000_0000, 0);
        check("burst_rd_rhs_count", obs_rhs - b_rhs, 4);
        check("burst_rd_beat0", obs_data[b_rhs % 16], 64'hA0A0_0000_0000_0000);
        check("burst_rd_beat3", obs_data[(b_rhs + 3) % 16], 64'hA0A0_0000_0000_0003);
        check("burst_rd_rlast_pos", obs_rlast_at - b_rhs, 4);
        check("burst_rd_resp_err", obs_err, 1);

        // burst write len 1, wready low 3 cycles, OKAY
        snap();
        do_write(32'h8000_2000, 8'd1, 3, 2'b00, -1, 64'h5555_0000_0000_0000);
        check("wr_aw_count", obs_aw - b_aw, 1);
        check("wr_ahead_count", obs_ahead - b_ahead, 1);
        check("wr_whs_count", obs_whs - b_whs, 2);
        check("wr_wlast_count", obs_wlast_cnt - b_wlast, 1);
        check("wr_wlast_pos", obs_wlast_at - b_whs, 2);
        check("wr_resp_err_okay", obs_err, 0);

        // same write with SLVERR
        do_write(32'h8000_2000, 8'd1, 3, 2'b10, -1, 64'h6666_0000_0000_0000);
        check("wr_resp_err_slverr", obs_err, 1);

        // request fields scrambled after acceptance
        snap();
        do_read(32'h8000_3000, 8'd1, 1, 1, 1, -1, 4'd0, 64'h0000_0000_CAFE_0000, 1);
        check("scramble_rhs_count", obs_rhs - b_rhs, 2);
        check("scramble_resp_err", obs_err, 0);

        // producer w_last disagrees with internal wlast
        do_write(32'h8000_4000, 8'd0, 0, 2'b00, 0, 64'h7);
        check("wlast_mismatch_err", obs_err, 1);

        // rid mismatch and rresp error on a later beat
        do_read(32'h8000_5000, 8'd0, 0, 0, 0, -1, 4'd3, 64'h9, 0);
        check("rid_mismatch_err", obs_err, 1);
        do_read(32'h8000_5100, 8'd1, 0, 0, 1, 1, 4'd0, 64'h10, 0);
        check("rresp_err", obs_err, 1);

        // 256-beat read: counter reaches 255 without wrapping
        snap();
        do_read(32'h8001_0000, 8'd255, 0, 0, 255, -1, 4'd0, 64'h1000, 0);
        check("len255_rhs_count", obs_rhs - b_rhs, 256);
        check("len255_rlast_pos", obs_rlast_at - b_rhs, 256);
        check("len255_last_data", obs_data[(b_rhs + 255) % 16], 64'h10FF);
        check("len255_resp_err", obs_err, 0);

        // reset during W beat 2 of 4
        snap();
        rw_valid = 1; rw_req = 1; rw_addr = 32'h8000_6000; rw_len = 8'd3; rw_size = 3'd3;
        w_strb = 8'hFF; rw_w_data = 64'h1; w_last = 0;
        tick();
        rw_valid = 0;
        wait_for("awvalid", 1);
        awready = 1; tick(); awready = 0;
        wait_for("wvalid", 2);
        wready = 1; tick(); tick(); wready = 0;
        check("rst_mid_wvalid_before", wvalid, 1);
        @(posedge clk);
        #2 rrst = 1;
        #1;
        check("rst_mid_wvalid", wvalid, 0);
        check("rst_mid_data_read", data_read, 0);
        check("rst_mid_rw_ready", rw_ready, 0);
        check("rst_mid_wlast", wlast, 0);
        tick(); tick();
        rrst = 0;
        tick();
        check("rst_mid_no_completion", obs_ready - b_ready, 0);
        snap();
        do_read(32'h8000_7000, 8'd0, 0, 0, 0, -1, 4'd0, 64'hBEEF, 0);
        check("post_rst_rhs", obs_rhs - b_rhs, 1);
        check("post_rst_data", obs_data[b_rhs % 16], 64'hBEEF);
        check("post_rst_resp_err", obs_err, 0);

        // back-to-back with rw_valid held high
        rw_valid = 1; rw_req = 0; rw_addr = 32'h8000_8000; rw_len = 8'd0; rw_size = 3'd3;
        tick();
        wait_for("arvalid", 0);
        arready = 1; tick(); arready = 0;
        wait_for("rready", 4);
        rvalid = 1; rdata = 64'h1; rlast = 1; tick(); rvalid = 0; rlast = 0;
        wait_for("rw_ready", 5);
        check("b2b_done_no_ar", arvalid, 0);
        tick();
        check("b2b_idle_no_ar", arvalid, 0);
        tick();
        check("b2b_accept_after_idle", arvalid, 1);
        rw_valid = 0;
        arready = 1; tick(); arready = 0;
        wait_for("rready", 4);
        rvalid = 1; rdata = 64'h2; rlast = 1; tick(); rvalid = 0; rlast = 0;
        wait_for("rw_ready", 5);
        check("b2b_second_resp_err", resp_err, 0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
